// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release, single/double click and
// long-press pulses; all timing is measured in ticks of an external strobe.
module button_event_decoder #(
  parameter int LONG_TICKS   = 1000,
  parameter int DCLICK_TICKS = 250,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic tick,
  output logic press,
  // 'release' is a reserved word in SystemVerilog, so the release pulse is release_evt.
  output logic release_evt,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESSED      = 3'd1,
    LONG_HELD    = 3'd2,
    WAIT_SECOND  = 3'd3,
    SECOND_PRESS = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Each branch sets held for the state being entered, so held is registered
  // alongside the state and never lags it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      press        <= 1'b0;
      release_evt  <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      press        <= 1'b0;
      release_evt  <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;

      case (state)
        IDLE: begin
          if (btn) begin
            state <= PRESSED;
            cnt   <= '0;
            press <= 1'b1;
            held  <= 1'b1;
          end else begin
            held <= 1'b0;
          end
        end

        PRESSED: begin
          if (!btn) begin
            state       <= WAIT_SECOND;
            cnt         <= '0;
            release_evt <= 1'b1;
            held        <= 1'b0;
          end else begin
            held <= 1'b1;
            if (tick) begin
              if (cnt == LONG_LAST) begin
                state      <= LONG_HELD;
                cnt        <= '0;
                long_press <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        // Counter is frozen here: long_press fires once per hold.
        LONG_HELD: begin
          if (!btn) begin
            state       <= IDLE;
            cnt         <= '0;
            release_evt <= 1'b1;
            held        <= 1'b0;
          end else begin
            held <= 1'b1;
          end
        end

        // A new press wins over a coinciding timeout.
        WAIT_SECOND: begin
          if (btn) begin
            state        <= SECOND_PRESS;
            cnt          <= '0;
            press        <= 1'b1;
            double_click <= 1'b1;
            held         <= 1'b1;
          end else begin
            held <= 1'b0;
            if (tick) begin
              if (cnt == DCLICK_LAST) begin
                state        <= IDLE;
                cnt          <= '0;
                single_click <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        SECOND_PRESS: begin
          if (!btn) begin
            state       <= IDLE;
            cnt         <= '0;
            release_evt <= 1'b1;
            held        <= 1'b0;
          end else begin
            held <= 1'b1;
            if (tick) begin
              if (cnt == LONG_LAST) begin
                state      <= LONG_HELD;
                cnt        <= '0;
                long_press <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_TICKS=4, DCLICK_TICKS=3.
// Expected vectors are {press, release, single, double, long, held}.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic reset_n;
  logic btn;
  logic tick;
  logic press, release_evt, single_click, double_click, long_press, held;

  int n_cmp = 0;
  int n_mis = 0;

  button_event_decoder #(
    .LONG_TICKS  (4),
    .DCLICK_TICKS(3),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn),
    .tick        (tick),
    .press       (press),
    .release_evt (release_evt),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .held        (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {press, release_evt, single_click, double_click, long_press, held};
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b (press,rel,sc,dc,lp,held)", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] exp);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    btn     = 1'b0;
    tick    = 1'b1;
    #12;
    check("reset_state", 6'b000000);
    reset_n = 1'b1;
    step("idle", 6'b000000);

    // Single click
    btn = 1'b1; step("sc_press", 6'b100001);
    step("sc_hold", 6'b000001);
    btn = 1'b0; step("sc_release", 6'b010000);
    step("sc_wait1", 6'b000000);
    step("sc_wait2", 6'b000000);
    step("sc_single", 6'b001000);
    step("sc_after", 6'b000000);

    // Double click
    btn = 1'b1; step("dc_press1", 6'b100001);
    step("dc_hold1", 6'b000001);
    btn = 1'b0; step("dc_release1", 6'b010000);
    btn = 1'b1; step("dc_double", 6'b100101);
    step("dc_hold2", 6'b000001);
    btn = 1'b0; step("dc_release2", 6'b010000);
    for (int i = 0; i < 4; i++) step("dc_no_single", 6'b000000);

    // Long press, 8 cycles held
    btn = 1'b1; step("lp_press", 6'b100001);
    for (int i = 0; i < 3; i++) step("lp_count", 6'b000001);
    step("lp_long", 6'b000011);
    for (int i = 0; i < 3; i++) step("lp_no_repeat", 6'b000001);
    btn = 1'b0; step("lp_release", 6'b010000);
    for (int i = 0; i < 4; i++) step("lp_no_click", 6'b000000);

    // Press on the same edge as the double-click timeout
    btn = 1'b1; step("sim_press", 6'b100001);
    btn = 1'b0; step("sim_release", 6'b010000);
    step("sim_wait1", 6'b000000);
    step("sim_wait2", 6'b000000);
    btn = 1'b1; step("sim_double_wins", 6'b100101);
    btn = 1'b0; step("sim_release2", 6'b010000);
    step("sim_idle", 6'b000000);

    // Long press on the second press of a double click
    btn = 1'b1; step("sp_press1", 6'b100001);
    btn = 1'b0; step("sp_release1", 6'b010000);
    btn = 1'b1; step("sp_double", 6'b100101);
    for (int i = 0; i < 3; i++) step("sp_count", 6'b000001);
    step("sp_long", 6'b000011);
    btn = 1'b0; step("sp_release2", 6'b010000);
    for (int i = 0; i < 4; i++) step("sp_no_click", 6'b000000);

    // Gated tick: strobe every 4th cycle, 20 cycles held
    tick = 1'b0;
    btn = 1'b1; step("gt_press", 6'b100001);
    for (int i = 1; i < 20; i++) begin
      tick = (i % 4 == 0);
      step((i == 16) ? "gt_long" : "gt_hold", (i == 16) ? 6'b000011 : 6'b000001);
    end
    tick = 1'b1;
    btn = 1'b0; step("gt_release", 6'b010000);
    step("gt_idle", 6'b000000);

    // Reset in PRESSED, btn still held after release
    btn = 1'b1; step("rs_press", 6'b100001);
    step("rs_cnt1", 6'b000001);
    step("rs_cnt2", 6'b000001);
    reset_n = 1'b0;
    #2;
    check("rs_async_clear", 6'b000000);
    step("rs_held_low", 6'b000000);
    reset_n = 1'b1;
    step("rs_repress", 6'b100001);
    for (int i = 0; i < 3; i++) step("rs_recount", 6'b000001);
    step("rs_long", 6'b000011);
    btn = 1'b0; step("rs_release", 6'b010000);
    step("rs_idle", 6'b000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 1000, ticks of continuous hold that qualify as a long press (legal range 1..2^CNT_W-1).
REQ-002 SHALL have parameter DCLICK_TICKS, default 250, ticks after a release during which a new press counts as a double click (legal range 1..2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 16, width of the internal tick counter.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn, input, 1, debounced, clk-synchronous button level, 1 = pressed.
REQ-007 SHALL have port tick, input, 1, single-cycle time-base strobe; all timing is counted in ticks.
REQ-008 SHALL have port press, output, 1, one-cycle pulse per accepted press.
REQ-009 SHALL have port release, output, 1, one-cycle pulse per accepted release.
REQ-010 SHALL have port single_click, output, 1, one-cycle pulse when a short press is not followed by a second press in time.
REQ-011 SHALL have port double_click, output, 1, one-cycle pulse on the second press of a double click.
REQ-012 SHALL have port long_press, output, 1, one-cycle pulse when a hold reaches LONG_TICKS.
REQ-013 SHALL have port held, output, 1, level, 1 while the FSM is in a pressed state.

Function
REQ-014 SHALL implement FSM states IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESS.
REQ-015 SHALL register all outputs; each pulse SHALL assert in the cycle after the clock edge on which the causing btn/tick condition is sampled (1-cycle latency).
REQ-016 SHALL clear the tick counter on every state transition and increment it only on tick=1 in PRESSED, SECOND_PRESS and WAIT_SECOND.
REQ-017 SHALL, in IDLE with btn=1, go to PRESSED and pulse press.
REQ-018 SHALL, in PRESSED with btn=0, go to WAIT_SECOND and pulse release.
REQ-019 SHALL, in PRESSED with btn=1, tick=1 and counter==LONG_TICKS-1, go to LONG_HELD and pulse long_press.
REQ-020 SHALL, in LONG_HELD with btn=0, go to IDLE and pulse release; long_press SHALL NOT repeat while held, and no single_click or double_click SHALL follow.
REQ-021 SHALL, in WAIT_SECOND with btn=1, go to SECOND_PRESS and pulse press and double_click in the same cycle.
REQ-022 SHALL, in WAIT_SECOND with btn=0, tick=1 and counter==DCLICK_TICKS-1, go to IDLE and pulse single_click.
REQ-023 SHALL, in SECOND_PRESS with btn=0, go to IDLE and pulse release.
REQ-024 SHALL, in SECOND_PRESS with btn=1, tick=1 and counter==LONG_TICKS-1, go to LONG_HELD and pulse long_press.
REQ-025 SHALL give the btn change priority over timeout when both occur in the same cycle (e.g. WAIT_SECOND: double_click, no single_click).
REQ-026 SHALL drive held=1 exactly in PRESSED, LONG_HELD and SECOND_PRESS.
REQ-027 SHALL never pulse more than one of single_click, double_click and long_press in one cycle.
REQ-028 SHALL hold the counter (no wrap) in states that do not count.
REQ-029 SHALL treat illegal state encodings as IDLE on the next edge.

Reset
REQ-030 SHALL, on reset_n=0, immediately force state IDLE, counter 0, and all outputs 0, independent of clk.
REQ-031 SHALL, when reset releases with btn=1, accept a press (press pulse) on the first clock edge after release.

Verification (LONG_TICKS=4, DCLICK_TICKS=3, tick=1 every cycle unless stated)
REQ-032 SHALL cover single click: btn 0->1 for 2 cycles then 0 -> press at edge+1, release after 2 cycles, single_click 3 cycles after release, no double_click.
REQ-033 SHALL cover double click: btn 1 for 2 cycles, 0 for 1 cycle, 1 for 2 cycles, then 0 -> press, release, then press and double_click in the same cycle, then release, no single_click.
REQ-034 SHALL cover long press: btn 1 for 8 cycles -> press, then exactly one long_press 4 cycles later, held=1 throughout, release on btn 0, no click pulses.
REQ-035 SHALL cover the simultaneous event: in WAIT_SECOND, btn rises on the same edge where counter==2 and tick=1 -> double_click=1, single_click=0.
REQ-036 SHALL cover a gated tick: tick every 4th cycle, btn held 20 cycles -> long_press when the 4th tick is sampled, not before.
REQ-037 SHALL cover reset mid-operation: reset_n pulsed low in PRESSED -> all outputs 0 asynchronously; btn still 1 after release -> one press pulse, counting restarts from 0.
